// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round/game sequencer sitting between the RNGs/clock divider
// and the display stages. Runs the countdown, judges submitted answers, keeps
// the BCD score, lives and level, and pulses new_round to draw the next target.
module game_round_ctrl #(
    parameter int ROUNDS_PER_LEVEL = 3,
    parameter int FEEDBACK_SEC     = 2,
    parameter int START_LIVES      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        submit_n,
    input  logic        start_n,
    input  logic [7:0]  target,
    input  logic [7:0]  answer,
    output logic        new_round,
    output logic [1:0]  level,
    output logic [5:0]  time_left,
    output logic [15:0] score_bcd,
    output logic [1:0]  lives,
    output logic [2:0]  status
);
    localparam int RW = $clog2(ROUNDS_PER_LEVEL + 1);
    localparam int FW = $clog2(FEEDBACK_SEC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PLAY, S_CORRECT, S_WRONG, S_OVER, S_WIN
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    level_q, level_d;
    logic [5:0]    time_q, time_d;
    logic [15:0]   score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic [RW-1:0] rounds_q, rounds_d;
    logic [FW-1:0] fb_q, fb_d;

    logic [1:0]    sub_sync, start_sync;
    logic          sub_prev, start_prev;
    logic          submit_press, start_press;

    // Seconds allowed per round at each level.
    function automatic logic [5:0] level_time(input logic [1:0] l);
        case (l)
            2'd1:    return 6'd30;
            2'd2:    return 6'd40;
            default: return 6'd50;
        endcase
    endfunction

    // Points for a correct answer, expressed as a hundreds digit.
    function automatic logic [3:0] level_pts(input logic [1:0] l);
        case (l)
            2'd1:    return 4'd1;
            2'd2:    return 4'd2;
            default: return 4'd6;
        endcase
    endfunction

    // Adds d hundreds to a 4-digit BCD score; overflow past 9999 pins at 9999.
    function automatic logic [15:0] bcd_add_hundreds(input logic [15:0] s, input logic [3:0] d);
        logic [4:0]  hs, ts;
        logic [15:0] r;
        hs = {1'b0, s[11:8]} + {1'b0, d};
        ts = {1'b0, s[15:12]};
        if (hs > 5'd9) begin
            hs = hs - 5'd10;
            ts = ts + 5'd1;
        end
        if (ts > 5'd9) r = 16'h9999;
        else           r = {ts[3:0], hs[3:0], s[7:0]};
        return r;
    endfunction

    // Two-flop synchronizers plus an edge-detect flop for both raw buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_sync   <= 2'b11;
            start_sync <= 2'b11;
            sub_prev   <= 1'b1;
            start_prev <= 1'b1;
        end else begin
            sub_sync   <= {sub_sync[0], submit_n};
            start_sync <= {start_sync[0], start_n};
            sub_prev   <= sub_sync[1];
            start_prev <= start_sync[1];
        end
    end

    // A press is the synchronized level falling; holding the button gives one event.
    assign submit_press = sub_prev & ~sub_sync[1];
    assign start_press  = start_prev & ~start_sync[1];

    // State and game-datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            level_q  <= 2'd1;
            time_q   <= 6'd30;
            score_q  <= 16'h0000;
            lives_q  <= 2'(START_LIVES);
            rounds_q <= '0;
            fb_q     <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            time_q   <= time_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            rounds_q <= rounds_d;
            fb_q     <= fb_d;
        end
    end

    // Next-state and datapath updates; everything holds unless a rule fires.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        time_d   = time_q;
        score_d  = score_q;
        lives_d  = lives_q;
        rounds_d = rounds_q;
        fb_d     = fb_q;
        case (state_q)
            S_IDLE, S_OVER, S_WIN: begin
                if (start_press) begin
                    score_d  = 16'h0000;
                    lives_d  = 2'(START_LIVES);
                    level_d  = 2'd1;
                    rounds_d = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                time_d  = level_time(level_q);
                state_d = S_PLAY;
            end
            S_PLAY: begin
                // Submit has priority over the tick so the final second still counts.
                if (submit_press) begin
                    fb_d = '0;
                    if (answer == target) begin
                        score_d  = bcd_add_hundreds(score_q, level_pts(level_q));
                        rounds_d = rounds_q + RW'(1);
                        state_d  = S_CORRECT;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = (lives_q == 2'd1) ? S_OVER : S_WRONG;
                    end
                end else if (tick_1hz) begin
                    if (time_q <= 6'd1) begin
                        time_d  = 6'd0;
                        state_d = S_OVER;
                    end else begin
                        time_d = time_q - 6'd1;
                    end
                end
            end
            S_CORRECT, S_WRONG: begin
                if (tick_1hz) begin
                    if (fb_q + FW'(1) == FW'(FEEDBACK_SEC)) begin
                        fb_d    = '0;
                        state_d = S_LOAD;
                        if (state_q == S_CORRECT && rounds_q == RW'(ROUNDS_PER_LEVEL)) begin
                            if (level_q == 2'd3) begin
                                state_d = S_WIN;
                            end else begin
                                level_d  = level_q + 2'd1;
                                rounds_d = '0;
                            end
                        end
                    end else begin
                        fb_d = fb_q + FW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status code seen by the LED stage; the load cycle already reads as PLAY.
    always_comb begin
        status = 3'd0;
        case (state_q)
            S_LOAD, S_PLAY: status = 3'd1;
            S_CORRECT:      status = 3'd2;
            S_WRONG:        status = 3'd3;
            S_OVER:         status = 3'd4;
            S_WIN:          status = 3'd5;
            default:        status = 3'd0;
        endcase
    end

    assign new_round = (state_q == S_LOAD);
    assign level     = level_q;
    assign time_left = time_q;
    assign score_bcd = score_q;
    assign lives     = lives_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed game scenarios plus a random phase, every cycle
// compared against an integer-arithmetic model of the game rules.
module tb_game_round_ctrl;
    localparam int RPL = 3;
    localparam int FB  = 2;
    localparam int SL  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_1hz = 1'b0;
    logic        submit_n = 1'b1;
    logic        start_n = 1'b1;
    logic [7:0]  target = 8'd0;
    logic [7:0]  answer = 8'd0;
    logic        new_round;
    logic [1:0]  level;
    logic [5:0]  time_left;
    logic [15:0] score_bcd;
    logic [1:0]  lives;
    logic [2:0]  status;

    int checks = 0;
    int failures = 0;
    int nr_count = 0;
    bit live_chk = 1'b0;
    bit nr_prev = 1'b0;

    game_round_ctrl #(.ROUNDS_PER_LEVEL(RPL), .FEEDBACK_SEC(FB), .START_LIVES(SL)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .submit_n(submit_n),
        .start_n(start_n), .target(target), .answer(answer), .new_round(new_round),
        .level(level), .time_left(time_left), .score_bcd(score_bcd), .lives(lives),
        .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: status code, pending-load flag, plain integer game values.
    int m_st, m_lvl, m_time, m_score, m_lives, m_rounds, m_fb;
    bit m_load;
    bit [2:0] sub_h, st_h;   // pin samples at the last three edges, [0] newest

    function automatic int lvl_time(input int l);
        return 20 + 10 * l;
    endfunction

    function automatic int lvl_pts(input int l);
        return (l == 1) ? 100 : (l == 2) ? 200 : 600;
    endfunction

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
    endfunction

    always @(posedge clk or negedge reset) begin
        bit sp, tp;
        if (!reset) begin
            m_st = 0; m_load = 0; m_lvl = 1; m_time = 30; m_score = 0;
            m_lives = SL; m_rounds = 0; m_fb = 0; sub_h = 3'b111; st_h = 3'b111;
        end else begin
            sp = sub_h[2] & ~sub_h[1];
            tp = st_h[2] & ~st_h[1];
            sub_h = {sub_h[1:0], submit_n};
            st_h  = {st_h[1:0], start_n};
            if (m_load) begin
                m_time = lvl_time(m_lvl);
                m_load = 0;
            end else if (m_st == 0 || m_st == 4 || m_st == 5) begin
                if (tp) begin
                    m_score = 0; m_lives = SL; m_lvl = 1; m_rounds = 0;
                    m_load = 1; m_st = 1;
                end
            end else if (m_st == 1) begin
                if (sp) begin
                    m_fb = 0;
                    if (answer == target) begin
                        m_score = (m_score + lvl_pts(m_lvl) > 9999) ? 9999 : m_score + lvl_pts(m_lvl);
                        m_rounds++;
                        m_st = 2;
                    end else begin
                        m_lives--;
                        m_st = (m_lives == 0) ? 4 : 3;
                    end
                end else if (tick_1hz) begin
                    if (m_time == 1) begin m_time = 0; m_st = 4; end
                    else m_time--;
                end
            end else if (tick_1hz) begin
                m_fb++;
                if (m_fb == FB) begin
                    m_fb = 0;
                    if (m_st == 2 && m_rounds == RPL && m_lvl == 3) begin
                        m_st = 5;
                    end else begin
                        if (m_st == 2 && m_rounds == RPL) begin
                            m_lvl++;
                            m_rounds = 0;
                        end
                        m_load = 1;
                        m_st = 1;
                    end
                end
            end
        end
    end

    // Whole-output comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (live_chk) begin
            chk("new_round", new_round, m_load);
            chk("status", status, m_st);
            chk("level", level, m_lvl);
            chk("time_left", time_left, m_time);
            chk("score", score_bcd, to_bcd(m_score));
            chk("lives", lives, m_lives);
            chk("nr_double", int'(nr_prev & new_round), 0);
        end
        nr_prev = new_round;
        nr_count += int'(new_round);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    endtask

    task automatic press_start();
        start_n = 1'b0; cyc(1); start_n = 1'b1; cyc(4);
    endtask

    task automatic press_submit();
        submit_n = 1'b0; cyc(1); submit_n = 1'b1; cyc(4);
    endtask

    // Tick lands on the same edge the submit press reaches the controller.
    task automatic submit_with_tick();
        submit_n = 1'b0; cyc(1); submit_n = 1'b1; cyc(1);
        tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0; cyc(2);
    endtask

    task automatic round_ok();
        answer = target;
        press_submit();
        tick(); tick();
        target = 8'($urandom_range(0, 99));
        cyc(1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int nr0;
        @(negedge clk);
        reset = 1'b0;
        cyc(2);
        live_chk = 1'b1;
        chk("rst_status", status, 0);
        chk("rst_level", level, 1);
        chk("rst_time", time_left, 30);
        chk("rst_score", score_bcd, 16'h0000);
        chk("rst_lives", lives, SL);
        chk("rst_nr", new_round, 0);
        release_reset();

        // Start and countdown.
        target = 8'd7;
        nr0 = nr_count;
        press_start();
        chk("start_nr_pulses", nr_count - nr0, 1);
        chk("start_status", status, 1);
        chk("start_level", level, 1);
        chk("start_time", time_left, 30);
        repeat (5) tick();
        chk("time_after_5", time_left, 25);

        // First correct answer and feedback wait.
        answer = 8'h07;
        press_submit();
        chk("c1_status", status, 2);
        chk("c1_score", score_bcd, 16'h0100);
        tick(); tick();
        chk("c1_new_round", new_round, 1);
        cyc(1);
        chk("c1_time", time_left, 30);

        // Level progression to a win.
        round_ok(); round_ok();
        chk("l2_level", level, 2);
        chk("l2_time", time_left, 40);
        repeat (3) round_ok();
        chk("l3_score", score_bcd, 16'h0900);
        chk("l3_level", level, 3);
        repeat (3) round_ok();
        chk("win_status", status, 5);
        chk("win_score", score_bcd, 16'h2700);

        // Saturation: reach L3, preload 9700, score once more.
        press_start();
        repeat (6) round_ok();
        m_score = 9700;
        force dut.score_q = 16'h9700;
        cyc(2);
        release dut.score_q;
        round_ok();
        chk("sat_score", score_bcd, 16'h9999);

        // Three wrong answers end the game with no feedback wait.
        target = 8'd5; answer = 8'd4;
        press_submit();
        chk("w1_lives", lives, 2);
        chk("w1_status", status, 3);
        tick(); tick(); cyc(1);
        press_submit();
        chk("w2_lives", lives, 1);
        tick(); tick(); cyc(1);
        nr0 = nr_count;
        press_submit();
        chk("w3_status", status, 4);
        tick(); tick(); cyc(2);
        chk("w3_hold_status", status, 4);
        chk("w3_no_round", nr_count - nr0, 0);
        press_start();
        chk("rs_score", score_bcd, 16'h0000);
        chk("rs_lives", lives, 3);
        chk("rs_level", level, 1);

        // Timeout, then a correct submit in the final second.
        repeat (29) tick();
        chk("to_time1", time_left, 1);
        tick();
        chk("to_time0", time_left, 0);
        chk("to_status", status, 4);
        press_start();
        answer = target;
        repeat (29) tick();
        submit_with_tick();
        chk("last_sec_status", status, 2);
        chk("last_sec_time", time_left, 1);
        tick(); tick(); cyc(2);

        // Reset in the middle of a round.
        pulse_reset();
        chk("mid_rst_status", status, 0);
        chk("mid_rst_time", time_left, 30);
        chk("mid_rst_score", score_bcd, 16'h0000);
        chk("mid_rst_lives", lives, SL);
        chk("mid_rst_level", level, 1);
        release_reset();

        // Random play.
        for (int it = 0; it < 500; it++) begin
            int act;
            if (new_round) target = 8'($urandom_range(0, 99));
            act = int'($urandom_range(0, 9));
            answer = ($urandom_range(0, 4) < 3) ? target : target + 8'($urandom_range(1, 255));
            case (act)
                0, 1, 2, 3: tick();
                4:          press_submit();
                5:          press_start();
                6:          cyc(int'($urandom_range(1, 3)));
                7:          submit_with_tick();
                8: begin
                    submit_n = 1'b0; cyc(int'($urandom_range(2, 6)));
                    submit_n = 1'b1; cyc(3);
                end
                default: begin
                    start_n = 1'b0; cyc(int'($urandom_range(2, 6)));
                    start_n = 1'b1; cyc(3);
                end
            endcase
            if (it == 250) begin
                pulse_reset();
                release_reset();
            end
        end

        live_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round/game controller directly downstream of the random-number generators and clock divider.
- Each round:
  - starts the countdown;
  - compares the player's switch answer against the displayed decimal target on a submit press;
  - updates the BCD score, lives and level;
  - pulses `new_round` so the RNGs draw the next target.
- Feeds the seven-segment and LED display stages with time left, score, level and status.

Parameters:
- ROUNDS_PER_LEVEL, 3, correct answers needed to advance a level.
- FEEDBACK_SEC, 2, tick_1hz pulses spent in CORRECT/WRONG before the next round.
- START_LIVES, 3, lives at game start (1..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; clock clk.
- tick_1hz  in  1  one-clk-wide pulse once per second from the clock divider.
- submit_n  in  1  raw active-low push button (key[1]); asynchronous to clk.
- start_n  in  1  raw active-low push button; leaves IDLE/GAME_OVER/WIN.
- target  in  8  binary value of current decimal target, stable from new_round+1 until next new_round.
- answer  in  8  sw[7:0], player's binary answer.
- new_round  out  1  one-cycle pulse; RNG advance + display refresh.
- level  out  2  1..3 current level.
- time_left  out  6  seconds remaining, binary.
- score_bcd  out  16  four BCD digits, [15:12] thousands.
- lives  out  2  remaining lives.
- status  out  3  0 IDLE, 1 PLAY, 2 CORRECT, 3 WRONG, 4 GAME_OVER, 5 WIN.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - new_round = 0, level = 1, time_left = 30, score_bcd = 0, lives = START_LIVES, status = 0.
  - round counter = 0, feedback counter = 0.
  - Synchronizer and edge-detect flops = 1 (released).
- Inputs:
  - submit_n and start_n: each passes through a 2-flop synchronizer.
  - Press = synchronized value falling 1 -> 0, giving a one-cycle event; a held button yields one event only.
  - No debounce; the bench drives clean edges.
- Level times: L1 = 30, L2 = 40, L3 = 50 s.
- IDLE:
  - On start press -> LOAD.
  - score := 0, lives := START_LIVES, level := 1, round counter := 0.
- LOAD (1 cycle):
  - new_round = 1.
  - time_left := level time.
  - -> PLAY.
- PLAY:
  - tick_1hz decrements time_left.
  - submit press: answer == target -> CORRECT, otherwise -> WRONG.
  - Timeout: tick_1hz while time_left == 1 sets time_left := 0 and -> GAME_OVER.
  - Simultaneous submit press and tick: the submit wins and time_left is frozen; a correct answer in the final second counts.
  - start presses are ignored in PLAY.
- CORRECT, on entry (same edge as the transition):
  - score += 100 / 200 / 600 for L1 / L2 / L3.
  - BCD add into hundreds with carry to thousands; saturate at 9999 (any carry out of the thousands digit -> 9999).
  - round counter += 1.
- WRONG, on entry:
  - lives -= 1.
  - If lives becomes 0, go straight to GAME_OVER (no feedback wait).
- Feedback wait (CORRECT or WRONG):
  - feedback counter counts tick_1hz up to FEEDBACK_SEC.
  - Then, from CORRECT: if round counter == ROUNDS_PER_LEVEL:
    - level 3 -> WIN;
    - otherwise level += 1, round counter := 0, -> LOAD.
  - Otherwise -> LOAD.
  - submit presses are ignored during feedback.
- GAME_OVER and WIN:
  - score, level and time_left hold.
  - start press -> same actions as from IDLE (full restart).
- time_left never underflows; it holds in all non-PLAY states.
- new_round asserts only in LOAD and is never high for two consecutive cycles.
- Reset asserted mid-round: all state returns to reset values immediately (asynchronously). After release the FSM waits in IDLE.
- Submit latency: press edge at pin -> status change 3 clk later (2 sync + 1 register).

Test Plan:
- Reset, start press -> new_round pulses once, status 1, level 1, time_left 30; five ticks -> time_left 25.
- L1, target 7, answer 8'h07, submit -> status 2, score_bcd 16'h0100; two ticks -> new_round pulse, time_left 30.
- Three correct at L1 -> level 2, time_left 40; three correct at L2 -> score_bcd 16'h0900, level 3; three correct at L3 -> status 5, score_bcd 16'h2700.
- Preload score 16'h9700 at L3, correct answer -> score_bcd 16'h9999 (saturated).
- Wrong answer three times (target 5, answer 4) -> lives 2, 1, then status 4 with no feedback wait; start press -> score 0, lives 3, level 1.
- Let time_left run to 1; tick alone -> time_left 0, status 4. Repeat with tick and a correct submit in the same cycle -> status 2, time_left stays 1. Assert reset during PLAY -> all outputs at reset values.
